pipe_ctrl: RTL and testbench

//  Central pipeline controller driving stall_o[5:0] and flush_o into every pipeline register (if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 66 ++++++
 tb/tb_pipe_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall encodings, stall-vector bit indices and controller states
package pipe_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int ST_PC  = 0;
    localparam int ST_IF  = 1;
    localparam int ST_ID  = 2;
    localparam int ST_EX  = 3;
    localparam int ST_MEM = 4;
    localparam int ST_WB  = 5;

    localparam logic [31:0] ZERO_WORD = 32'h0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    // Highest requesting stage stops itself and everything upstream of it
    function automatic logic [5:0] stall_vec(input logic m, input logic e, input logic d, input logic f);
        logic [5:0] v;
        v         = '0;
        v[ST_PC]  = (m | e | d | f) ? STOP : NO_STOP;
        v[ST_IF]  = (m | e | d | f) ? STOP : NO_STOP;
        v[ST_ID]  = (m | e | d) ? STOP : NO_STOP;
        v[ST_EX]  = (m | e) ? STOP : NO_STOP;
        v[ST_MEM] = m ? STOP : NO_STOP;
        v[ST_WB]  = NO_STOP;
        return v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall requests, trap redirect and pipeline control outputs
interface pipe_ctrl_if #(parameter int CNT_W = 32);

    logic             stall_if_i;
    logic             stall_id_i;
    logic             stall_ex_i;
    logic             stall_mem_i;
    logic             trap_req_i;
    logic [31:0]      trap_pc_i;
    logic [5:0]       stall_o;
    logic             flush_o;
    logic [31:0]      new_pc_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output stall_if_i, stall_id_i, stall_ex_i, stall_mem_i, trap_req_i, trap_pc_i,
        input  stall_o, flush_o, new_pc_o, timeout_o, stall_cnt_o
    );

    modport slave (
        input  stall_if_i, stall_id_i, stall_ex_i, stall_mem_i, trap_req_i, trap_pc_i,
        output stall_o, flush_o, new_pc_o, timeout_o, stall_cnt_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stall requests, sequences trap flushes behind LSU traffic, mem watchdog and stall counter
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pipe_ctrl_if.slave bus
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stall;

    // Next state: first trap is latched; a trap arriving under LSU traffic waits for it to drain
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: begin
                if (bus.trap_req_i) begin
                    state_d = bus.stall_mem_i ? WAIT_MEM : FLUSH;
                    pc_d    = bus.trap_pc_i;
                end
            end
            WAIT_MEM: state_d = bus.stall_mem_i ? WAIT_MEM : FLUSH;
            default:  state_d = RUN;
        endcase
    end

    // Outputs, watchdog and saturating stall counter next values
    always_comb begin
        stall = (state_q == FLUSH)    ? '0 :
                (state_q == WAIT_MEM) ? stall_vec(1'b1, 1'b0, 1'b0, 1'b0) :
                stall_vec(bus.stall_mem_i, bus.stall_ex_i, bus.stall_id_i, bus.stall_if_i);
        bus.stall_o     = stall;
        bus.flush_o     = (state_q == FLUSH);
        bus.new_pc_o    = (state_q == FLUSH) ? pc_q : ZERO_WORD;
        bus.timeout_o   = (MEM_TIMEOUT != 0) && bus.stall_mem_i && (wd_q == WD_W'(MEM_TIMEOUT - 1));
        bus.stall_cnt_o = cnt_q;
        wd_d  = !bus.stall_mem_i ? '0 : (wd_q == WD_W'(MEM_TIMEOUT)) ? wd_q : wd_q + 1'b1;
        cnt_d = (|stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            pc_q    <= ZERO_WORD;
            wd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed expectations for pipe_ctrl
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_ctrl_if #(.CNT_W(32)) bus ();

    pipe_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic e, input logic d, input logic f, input logic t, input logic [31:0] pc);
        bus.stall_mem_i = m;
        bus.stall_ex_i  = e;
        bus.stall_id_i  = d;
        bus.stall_if_i  = f;
        bus.trap_req_i  = t;
        bus.trap_pc_i   = pc;
        #2;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rst_stall", 32'(bus.stall_o), 32'h0);
        check("rst_flush", 32'(bus.flush_o), 32'h0);
        check("rst_pc", bus.new_pc_o, 32'h0);
        check("rst_to", 32'(bus.timeout_o), 32'h0);
        check("rst_cnt", bus.stall_cnt_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(0, 1, 0, 0, 0, 32'h0);
            check("ex_stall", 32'(bus.stall_o), 32'h0f);
        end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("ex_release", 32'(bus.stall_o), 32'h0);
        check("ex_cnt", bus.stall_cnt_o, 32'd3);
        drive(1, 0, 1, 0, 0, 32'h0);
        check("mem_id_stall", 32'(bus.stall_o), 32'h1f);
        tick();
        drive(0, 0, 1, 0, 0, 32'h0);
        check("id_stall", 32'(bus.stall_o), 32'h07);
        tick();
        drive(0, 0, 0, 1, 0, 32'h0);
        check("if_stall", 32'(bus.stall_o), 32'h03);
        tick();
        drive(0, 0, 0, 0, 1, 32'h100);
        check("trap_cyc_flush", 32'(bus.flush_o), 32'h0);
        check("prio_cnt", bus.stall_cnt_o, 32'd6);
        tick();
        drive(0, 1, 0, 0, 1, 32'hdead);
        check("trap_flush", 32'(bus.flush_o), 32'h1);
        check("trap_pc", bus.new_pc_o, 32'h100);
        check("trap_stall", 32'(bus.stall_o), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("post_flush", 32'(bus.flush_o), 32'h0);
        check("post_pc", bus.new_pc_o, 32'h0);
        check("flush_cnt", bus.stall_cnt_o, 32'd6);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("ignored_trap", 32'(bus.flush_o), 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check("def_c0_stall", 32'(bus.stall_o), 32'h1f);
        tick();
        drive(1, 0, 0, 0, 1, 32'h200);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check("def_c2_stall", 32'(bus.stall_o), 32'h1f);
        check("def_c2_flush", 32'(bus.flush_o), 32'h0);
        tick();
        drive(1, 0, 0, 0, 1, 32'h300);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check("def_c4_to", 32'(bus.timeout_o), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("def_c5_stall", 32'(bus.stall_o), 32'h1f);
        check("def_c5_flush", 32'(bus.flush_o), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("def_flush", 32'(bus.flush_o), 32'h1);
        check("def_pc", bus.new_pc_o, 32'h200);
        check("def_stall", 32'(bus.stall_o), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("def_after", 32'(bus.flush_o), 32'h0);
        check("def_cnt", bus.stall_cnt_o, 32'd12);
        for (int i = 0; i < 20; i++) begin
            tick();
            drive(1, 0, 0, 0, 0, 32'h0);
            check("wd_stall", 32'(bus.stall_o), 32'h1f);
            check("wd_pulse", 32'(bus.timeout_o), (i == 7) ? 32'h1 : 32'h0);
        end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("wd_cnt", bus.stall_cnt_o, 32'd32);
        for (int i = 0; i < 8; i++) begin
            tick();
            drive(1, 0, 0, 0, 0, 32'h0);
            check("wd_rearm", 32'(bus.timeout_o), (i == 7) ? 32'h1 : 32'h0);
        end
        tick();
        drive(1, 0, 0, 0, 1, 32'h400);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        check("rst_wm_stall", 32'(bus.stall_o), 32'h1f);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rst2_stall", 32'(bus.stall_o), 32'h0);
        check("rst2_flush", 32'(bus.flush_o), 32'h0);
        check("rst2_pc", bus.new_pc_o, 32'h0);
        check("rst2_to", 32'(bus.timeout_o), 32'h0);
        check("rst2_cnt", bus.stall_cnt_o, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rst2_noflush1", 32'(bus.flush_o), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        check("rst2_noflush2", 32'(bus.flush_o), 32'h0);
        check("rst2_nopc", bus.new_pc_o, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
